// File: rtl/tdm_demux8_pkg.sv
// Shared constants and types for the 1:8 time-division demultiplexer.
// Lane index width is derived from the lane count, so both modules agree on it.
package tdm_demux8_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = $clog2(NUM_LANES);

  typedef logic [SEL_W-1:0] lane_t;

  localparam lane_t LANE_RST = '0;
  localparam lane_t LANE_ONE = lane_t'(1);

endpackage : tdm_demux8_pkg

// File: rtl/tdm_lane_counter.sv
// Modulo-LANES lane select counter: increments per accepted sample and
// reloads to lane 1 when a realigning sync sample lands in lane 0.
module tdm_lane_counter
  import tdm_demux8_pkg::*;
#(
  parameter int LANES = NUM_LANES
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  load_one,
  output lane_t lane,
  output logic  is_last
);

  lane_t lane_d, lane_q;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    lane_d = lane_q;
    if (load_one) begin
      lane_d = LANE_ONE;
    end else if (inc) begin
      // Power-of-two lane count: the natural wrap from last lane to 0 is the frame close.
      lane_d = lane_q + lane_t'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, active-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= LANE_RST;
    end else begin
      lane_q <= lane_d;
    end
  end

  assign lane    = lane_q;
  assign is_last = (lane_q == lane_t'(LANES - 1));

endmodule : tdm_lane_counter

// File: rtl/tdm_demux8.sv
// Sequential 1:8 TDM demultiplexer: collects one lane sample per handshake into a
// shadow register and presents each complete frame as a parallel word with valid/ready.
module tdm_demux8
  import tdm_demux8_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int LANES = NUM_LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sync,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]       cur_lane,
  output logic                   frame_err
);

  lane_t lane;
  lane_t wr_lane;
  logic  is_last;
  logic  accept;
  logic  realign;
  logic  closing;

  logic [LANES*WIDTH-1:0] shadow_d, shadow_q;
  logic [LANES*WIDTH-1:0] out_data_d, out_data_q;
  logic                   out_valid_d, out_valid_q;
  logic                   frame_err_d, frame_err_q;

  tdm_lane_counter #(
    .LANES(LANES)
  ) u_lane_counter (
    .clk     (clk),
    .rst     (rst),
    .inc     (accept && !realign),
    .load_one(realign),
    .lane    (lane),
    .is_last (is_last)
  );

  // Only the frame-closing sample can be stalled, and only while the previous word is unread.
  assign in_ready = !(is_last && out_valid_q && !out_ready);

  always_comb begin
    accept      = in_valid && in_ready;
    realign     = accept && in_sync && (lane != LANE_RST);
    closing     = accept && is_last && !realign;
    wr_lane     = realign ? LANE_RST : lane;

    shadow_d    = shadow_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    frame_err_d = realign;

    if (accept) begin
      shadow_d[int'(wr_lane)*WIDTH +: WIDTH] = in_data;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    // A frame closing in the same cycle the old word is consumed keeps out_valid high.
    if (closing) begin
      out_valid_d = 1'b1;
      out_data_d  = shadow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cur_lane  = lane;
  assign frame_err = frame_err_q;

endmodule : tdm_demux8
